// File: rtl/adder_pipe_wrapper.sv
// Two-stage pipelined N-bit adder: operand register S1 -> carry-skip core -> result register S2.
// Latency 2 cycles, 1 beat/cycle; under backpressure both stages hold and in_ready drops only when both are full.

module adder_carry_skip #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    localparam int NB = N / 4;

    for (genvar k = 0; k < NB; k++) begin : g_blk
        logic       ci;
        logic       co;
        logic       rip_co;
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] s;

        if (k == 0) begin : g_c0
            assign ci = cin;
        end else begin : g_cn
            assign ci = g_blk[k-1].co;
        end

        assign p = a[4*k +: 4] ^ b[4*k +: 4];
        assign g = a[4*k +: 4] & b[4*k +: 4];

        always_comb begin
            logic c;
            c = ci;
            s = '0;
            for (int j = 0; j < 4; j++) begin
                s[j] = p[j] ^ c;
                c    = g[j] | (p[j] & c);
            end
            rip_co = c;
        end

        // A fully propagating block forwards its carry-in straight past the ripple chain.
        assign co = (&p) ? ci : rip_co;
        assign sum[4*k +: 4] = s;
    end

    assign cout = g_blk[NB-1].co;
endmodule

module adder_pipe_wrapper #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     sum,
    output logic             cout,
    output logic             ovf,
    output logic [CNT_W-1:0] txn_count
);
    logic [N-1:0]     a_q, b_q;
    logic             cin_q;
    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic [N-1:0]     sum_q;
    logic             cout_q, ovf_q;
    logic [CNT_W-1:0] txn_q;

    logic [N-1:0]     sum_core;
    logic             cout_core;
    logic             ovf_core;
    logic             s2_free, s1_advance, in_fire, out_fire;

    adder_carry_skip #(.N(N)) u_core (
        .a    (a_q),
        .b    (b_q),
        .cin  (cin_q),
        .sum  (sum_core),
        .cout (cout_core)
    );

    assign ovf_core   = (a_q[N-1] == b_q[N-1]) & (sum_core[N-1] != a_q[N-1]);
    assign s2_free    = !s2_valid_q | out_ready;
    assign s1_advance = s1_valid_q & s2_free;
    assign in_ready   = !s1_valid_q | s2_free;
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = s2_valid_q & out_ready;

    assign s1_valid_d = in_fire | (s1_valid_q & !s1_advance);
    assign s2_valid_d = s1_advance | (s2_valid_q & !out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            txn_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (in_fire) begin
                a_q   <= a;
                b_q   <= b;
                cin_q <= cin;
            end
            // Result registers keep their last value once drained.
            if (s1_advance) begin
                sum_q  <= sum_core;
                cout_q <= cout_core;
                ovf_q  <= ovf_core;
            end
            if (out_fire) begin
                txn_q <= txn_q + CNT_W'(1);
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign txn_count = txn_q;
endmodule
